seq_detector: RTL and testbench

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_detector_if.sv | 8 +
 rtl/seq_detector.sv | 44 ++++
 tb/tb_seq_detector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the serial 0110 pattern detector.
package seq_det_pkg;

    // State encodings: length of the useful prefix seen so far
    localparam logic [1:0] S0 = 2'd0;  // no useful prefix
    localparam logic [1:0] S1 = 2'd1;  // "0"
    localparam logic [1:0] S2 = 2'd2;  // "01"
    localparam logic [1:0] S3 = 2'd3;  // "011"

    // Target pattern, oldest bit in the MSB
    localparam logic [3:0] PATTERN = 4'b0110;

endpackage

// File: rtl/seq_detector_if.sv
// Serial bit stream bundle: source drives x, detector answers on z.
interface seq_detector_if;
    logic x;
    logic z;

    modport master (output x, input z);
    modport slave  (input x, output z);
endinterface

// File: rtl/seq_detector.sv
// Mealy FSM detecting serial pattern 0110 with overlap.
module seq_detector
    import seq_det_pkg::*;
(
    input  logic x,
    input  logic clk,
    input  logic reset,
    output logic z
);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_z;

    // State register; reset drops straight to S0 and discards any partial match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S0;
        else        r_state <= w_next;
    end

    // Next-state and Mealy output; defaults cover any unexpected encoding
    always_comb begin
        w_next = S0;
        w_z    = 1'b0;
        case (r_state)
            S0: w_next = x ? S0 : S1;
            S1: w_next = x ? S2 : S1;
            S2: w_next = x ? S3 : S1;
            S3: begin
                // trailing 0 of a hit doubles as leading 0 of the next one
                w_next = x ? S0 : S1;
                w_z    = (x == PATTERN[0]);
            end
            default: begin
                w_next = S0;
                w_z    = 1'b0;
            end
        endcase
    end

    // Output gated by reset so it is 0 whenever reset is held, whatever x does
    assign z = w_z & reset;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: driver queues expected z per bit, monitor checks.
module tb_seq_detector;
    import seq_det_pkg::*;

    logic clk;
    logic reset;
    logic vld;
    int   checks;
    int   errors;

    bit   exp_q[$];
    int   id_q[$];
    int   bit_id;

    seq_detector_if bus ();

    seq_detector dut (
        .x     (bus.x),
        .clk   (clk),
        .reset (reset),
        .z     (bus.z)
    );

    // Clock starts high so rising edges land at 10, 20, 30 ns
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] exp);
        checks++;
        if (dut.r_state !== exp) begin
            errors++;
            $display("FAIL %s state actual=%0d expected=%0d at %0t", name, dut.r_state, exp, $time);
        end
    endtask

    // Present one bit just after a rising edge and queue its expected z
    task automatic send(input bit xb, input bit ez);
        @(posedge clk);
        #1;
        bus.x = xb;
        exp_q.push_back(ez);
        id_q.push_back(bit_id);
        bit_id++;
        vld = 1'b1;
    endtask

    // Let the edge consume the last presented bit, then stop monitoring
    task automatic settle();
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    // Reset pulse placed between edges
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        vld   = 1'b0;
        reset = 1'b0;
        #5;
        reset = 1'b1;
    endtask

    task automatic send_seq(input logic [31:0] xs, input logic [31:0] zs, input int n);
        logic [31:0] xv, zv;
        xv = xs;
        zv = zs;
        for (int i = n - 1; i >= 0; i--) send(xv[i], zv[i]);
    endtask

    // Monitor: on every falling edge while a bit is presented, pop and compare z
    initial begin
        forever begin
            @(negedge clk);
            if (vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow z=%b at %0t", bus.z, $time);
                end else begin
                    automatic bit e  = exp_q.pop_front();
                    automatic int id = id_q.pop_front();
                    check_bit($sformatf("z_bit%0d", id), bus.z, e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        bit_id = 0;
        vld    = 1'b0;
        bus.x  = 1'b0;
        reset  = 1'b0;

        // Reset held: state S0, z forced low for either x
        #2;
        check_state("reset_state", S0);
        check_bit("reset_z_x0", bus.z, 1'b0);
        bus.x = 1'b1;
        #1;
        check_bit("reset_z_x1", bus.z, 1'b0);
        #12;
        reset = 1'b1;  // t = 15 ns

        // 0110 -> hit on bit 4
        send_seq(32'b0110, 32'b0001, 4);
        settle();

        // 00110 -> hit on bit 5 only
        pulse_reset();
        send_seq(32'b00110, 32'b00001, 5);
        settle();

        // Overlap 0110110 -> hits on bits 4 and 7
        pulse_reset();
        send_seq(32'b0110110, 32'b0001001, 7);
        settle();

        // Near-miss 0111010 -> never hits, S0 after bit 4
        pulse_reset();
        send_seq(32'b0111, 32'b0000, 4);
        @(posedge clk);
        #1;
        vld = 1'b0;
        check_state("nearmiss_after_bit4", S0);
        send_seq(32'b010, 32'b000, 3);
        settle();

        // Mid-operation reset from S3 discards the prefix
        pulse_reset();
        send_seq(32'b011, 32'b000, 3);
        @(posedge clk);
        #1;
        vld   = 1'b0;
        bus.x = 1'b0;
        #1;
        check_state("midreset_pre_S3", S3);
        check_bit("midreset_pre_z", bus.z, 1'b1);
        reset = 1'b0;
        #1;
        check_state("midreset_async_S0", S0);
        check_bit("midreset_z_forced", bus.z, 1'b0);
        #6;
        reset = 1'b1;
        send(1'b0, 1'b0);
        settle();
        check_state("midreset_after_0", S1);

        // 20 ones: never hits, holds S0
        pulse_reset();
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
        settle();
        check_state("ones_hold_S0", S0);

        // 20 zeros: never hits, holds S1
        for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
        settle();
        check_state("zeros_hold_S1", S1);

        // Everything queued must have been checked
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
